// File: rtl/mips_lsu.sv
`default_nettype none
// mips_lsu: memory-stage load/store unit for the EE180 MIPS pipeline.
// Handles sized loads/stores over a ready/wait handshake, an LL/SC reservation, and misalignment/timeout errors.
module mips_lsu #(
  parameter int BIG_ENDIAN   = 1,
  parameter int ADDR_W       = 32,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  input  logic              llbit_clr,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic [3:0]        mem_write_en,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  input  logic              mem_ready,
  output logic              resp_valid,
  output logic              resp_we,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic [ADDR_W-1:0] err_addr
);
  localparam logic [3:0] OP_LB = 4'd0, OP_LBU = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3,
                         OP_LW = 4'd4, OP_LL = 4'd5, OP_SB = 4'd8, OP_SH = 4'd9,
                         OP_SW = 4'd10, OP_SC = 4'd11;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam bit BE = (BIG_ENDIAN != 0);
  localparam bit TO_EN = (WAIT_TIMEOUT > 0);
  localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0]  count;
  logic              link_valid;
  logic [ADDR_W-3:0] link_word;
  logic [3:0]        op_q;
  logic [1:0]        off_q;
  logic              sc_ok_q;

  logic       op_ok, is_load, is_sc, is_ll, is_store;
  logic [1:0] size;
  logic [1:0] off, lane, lane_q;
  logic       hi_half, hi_half_q;
  logic       misaligned, word_match, link_hit;
  logic       active, issuing, bypass, timeout_hit, mem_done, complete, err_now;
  logic [3:0] lane_mask;
  logic [7:0] rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    op_ok = 1'b1; is_load = 1'b0; is_sc = 1'b0; is_ll = 1'b0; size = SZ_B;
    case (req_op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; size = SZ_H; end
      OP_LW:         begin is_load = 1'b1; size = SZ_W; end
      OP_LL:         begin is_load = 1'b1; is_ll = 1'b1; size = SZ_W; end
      OP_SB:         size = SZ_B;
      OP_SH:         size = SZ_H;
      OP_SW:         size = SZ_W;
      OP_SC:         begin is_sc = 1'b1; size = SZ_W; end
      default:       op_ok = 1'b0;
    endcase
  end

  assign is_store   = op_ok & ~is_load;
  assign off        = req_addr[1:0];
  assign lane       = BE ? ~off : off;
  assign hi_half    = BE ? ~off[1] : off[1];
  assign misaligned = ((size == SZ_H) & off[0]) | ((size == SZ_W) & (off != 2'b00));
  assign word_match = (link_word == req_addr[ADDR_W-1:2]);
  assign link_hit   = link_valid & word_match;

  // Reset gates issue so strobes drop the instant rst rises, even mid-wait.
  assign active      = ~rst & en & req_valid & op_ok;
  assign issuing     = active & ~misaligned & (~is_sc | link_hit);
  assign bypass      = active & ~issuing;
  assign timeout_hit = TO_EN & (state == S_WAIT) & (count == CNT_LAST) & ~mem_ready;
  assign mem_done    = issuing & mem_ready;
  assign complete    = mem_done | bypass | (issuing & timeout_hit);
  assign err_now     = (active & misaligned) | (issuing & timeout_hit);

  always_comb begin
    case (size)
      SZ_B:    lane_mask = 4'b0001 << lane;
      SZ_H:    lane_mask = hi_half ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  assign mem_addr       = req_addr;
  assign mem_read_en    = issuing & is_load;
  assign mem_write_en   = (issuing & is_store) ? lane_mask : 4'b0000;
  assign mem_write_data = (size == SZ_B) ? {4{req_wdata[7:0]}} :
                          (size == SZ_H) ? {2{req_wdata[15:0]}} : req_wdata;

  always_comb begin
    state_next = state;
    stall      = issuing & ~mem_ready & ~timeout_hit;
    case (state)
      S_IDLE:  if (issuing & ~mem_ready) state_next = S_WAIT;
      S_WAIT:  if (~issuing | mem_ready | timeout_hit) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      link_valid <= 1'b0;
      link_word  <= '0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_err   <= 1'b0;
      resp_rd    <= 5'd0;
      err_addr   <= '0;
      op_q       <= 4'd0;
      off_q      <= 2'd0;
      sc_ok_q    <= 1'b0;
    end else if (en) begin
      state      <= state_next;
      count      <= (state == S_WAIT && state_next == S_WAIT) ? count + 1'b1 : '0;
      resp_valid <= complete;
      if (complete) begin
        resp_rd  <= req_rd;
        resp_err <= err_now;
        resp_we  <= ~err_now & (is_load | is_sc);
        err_addr <= req_addr;
        op_q     <= req_op;
        off_q    <= off;
        sc_ok_q  <= mem_done;
      end
      // Errored completions (misaligned or timed out) leave the reservation alone.
      if (llbit_clr) begin
        link_valid <= 1'b0;
      end else if (mem_done & is_ll) begin
        link_valid <= 1'b1;
        link_word  <= req_addr[ADDR_W-1:2];
      end else if ((complete & ~err_now & is_sc) | (mem_done & is_store & word_match)) begin
        link_valid <= 1'b0;
      end
    end
  end

  assign lane_q    = BE ? ~off_q : off_q;
  assign hi_half_q = BE ? ~off_q[1] : off_q[1];
  assign rd_byte   = mem_read_data[{lane_q, 3'b000} +: 8];
  assign rd_half   = hi_half_q ? mem_read_data[31:16] : mem_read_data[15:0];

  always_comb begin
    resp_data = 32'd0;
    case (op_q)
      OP_LB:        resp_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:       resp_data = {24'd0, rd_byte};
      OP_LH:        resp_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:       resp_data = {16'd0, rd_half};
      OP_LW, OP_LL: resp_data = mem_read_data;
      OP_SC:        resp_data = {31'd0, sc_ok_q};
      default:      resp_data = 32'd0;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_mips_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// tb_mips_lsu: directed self-checking bench; a big-endian untimed instance and a
// little-endian instance with WAIT_TIMEOUT=4 share one stimulus stream.
module tb_mips_lsu;
  localparam logic [3:0] LB = 4'd0, LBU = 4'd1, LH = 4'd2, LHU = 4'd3, LW = 4'd4, LL = 4'd5,
                         SB = 4'd8, SH = 4'd9, SW = 4'd10, SC = 4'd11;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, req_valid = 1'b0, llbit_clr = 1'b0, mem_ready = 1'b1;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, mem_read_data = 32'h8081_7F01;
  logic [4:0]  req_rd = 5'd0;

  logic        b_stall, b_rd_en, b_rv, b_rwe, b_rerr;
  logic [3:0]  b_we;
  logic [4:0]  b_rrd;
  logic [31:0] b_addr, b_wd, b_rdata, b_eaddr;
  logic        l_stall, l_rd_en, l_rv, l_rwe, l_rerr;
  logic [3:0]  l_we;
  logic [4:0]  l_rrd;
  logic [31:0] l_addr, l_wd, l_rdata, l_eaddr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mips_lsu #(.BIG_ENDIAN(1), .ADDR_W(32), .WAIT_TIMEOUT(0)) u_be (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .llbit_clr(llbit_clr), .stall(b_stall),
    .mem_addr(b_addr), .mem_read_en(b_rd_en), .mem_write_en(b_we), .mem_write_data(b_wd),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready), .resp_valid(b_rv), .resp_we(b_rwe),
    .resp_rd(b_rrd), .resp_data(b_rdata), .resp_err(b_rerr), .err_addr(b_eaddr));

  mips_lsu #(.BIG_ENDIAN(0), .ADDR_W(32), .WAIT_TIMEOUT(4)) u_le (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .llbit_clr(llbit_clr), .stall(l_stall),
    .mem_addr(l_addr), .mem_read_en(l_rd_en), .mem_write_en(l_we), .mem_write_data(l_wd),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready), .resp_valid(l_rv), .resp_we(l_rwe),
    .resp_rd(l_rrd), .resp_data(l_rdata), .resp_err(l_rerr), .err_addr(l_eaddr));

  // Load table against memory word 0x8081_7F01.
  logic [3:0]  ld_op  [7] = '{LB, LBU, LB, LH, LHU, LW, LB};
  logic [1:0]  ld_off [7] = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd3};
  logic [31:0] ld_be  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'h0000_7F01,
                              32'h0000_8081, 32'h8081_7F01, 32'h0000_0001};
  logic [31:0] ld_le  [7] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FF81, 32'hFFFF_8081,
                              32'h0000_7F01, 32'h8081_7F01, 32'hFFFF_FF80};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rd = rd;
    #1;
  endtask

  task automatic test_reset();
    #12;
    tests++; if (b_rv !== 1'b0) begin fails++; $display("FAIL reset_rv got=%0h exp=0", b_rv); end
    tests++; if (b_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%0h exp=0", b_stall); end
    tests++; if (b_we !== 4'd0 || b_rd_en !== 1'b0) begin fails++; $display("FAIL reset_strobes got=%0h/%0h exp=0/0", b_we, b_rd_en); end
    tests++; if (b_rerr !== 1'b0 || b_rwe !== 1'b0 || b_rrd !== 5'd0 || b_eaddr !== 32'd0) begin
      fails++; $display("FAIL reset_resp got err=%0h we=%0h rd=%0h ea=%0h exp=0", b_rerr, b_rwe, b_rrd, b_eaddr); end
    tests++; if (l_rv !== 1'b0) begin fails++; $display("FAIL reset_rv_le got=%0h exp=0", l_rv); end
    rst = 1'b0;
    en  = 1'b1;
    tick();
  endtask

  task automatic test_loads();
    for (int i = 0; i < 7; i++) begin
      drive(ld_op[i], 32'h100 + 32'(ld_off[i]), 32'd0, 5'(i + 1));
      tests++; if (b_rd_en !== 1'b1 || b_stall !== 1'b0) begin fails++; $display("FAIL ld%0d_issue got rd_en=%0h stall=%0h exp=1/0", i, b_rd_en, b_stall); end
      tick();
      tests++; if (b_rv !== 1'b1 || b_rwe !== 1'b1 || b_rerr !== 1'b0) begin fails++; $display("FAIL ld%0d_resp got rv=%0h we=%0h err=%0h exp=1/1/0", i, b_rv, b_rwe, b_rerr); end
      tests++; if (b_rrd !== 5'(i + 1)) begin fails++; $display("FAIL ld%0d_rd got=%0h exp=%0h", i, b_rrd, i + 1); end
      tests++; if (b_rdata !== ld_be[i]) begin fails++; $display("FAIL ld%0d_be got=%h exp=%h", i, b_rdata, ld_be[i]); end
      tests++; if (l_rdata !== ld_le[i]) begin fails++; $display("FAIL ld%0d_le got=%h exp=%h", i, l_rdata, ld_le[i]); end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_stores();
    drive(SB, 32'h1001, 32'h1234_56AB, 5'd0);
    tests++; if (b_we !== 4'b0100 || l_we !== 4'b0010) begin fails++; $display("FAIL sb_we got be=%b le=%b exp=0100/0010", b_we, l_we); end
    tests++; if (b_wd !== 32'hABAB_ABAB || b_rd_en !== 1'b0) begin fails++; $display("FAIL sb_data got=%h rd_en=%0h exp=abababab/0", b_wd, b_rd_en); end
    tick();
    tests++; if (b_rv !== 1'b1 || b_rwe !== 1'b0) begin fails++; $display("FAIL sb_resp got rv=%0h we=%0h exp=1/0", b_rv, b_rwe); end
    drive(SH, 32'h1002, 32'hCAFE_BEEF, 5'd0);
    tests++; if (l_we !== 4'b1100 || b_we !== 4'b0011) begin fails++; $display("FAIL sh_we got le=%b be=%b exp=1100/0011", l_we, b_we); end
    tests++; if (l_wd !== 32'hBEEF_BEEF) begin fails++; $display("FAIL sh_data got=%h exp=beefbeef", l_wd); end
    tick();
    drive(SW, 32'h1004, 32'h0102_0304, 5'd0);
    tests++; if (b_we !== 4'b1111 || b_wd !== 32'h0102_0304) begin fails++; $display("FAIL sw got we=%b data=%h exp=1111/01020304", b_we, b_wd); end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    drive(LW, 32'h2002, 32'd0, 5'd7);
    tests++; if (b_rd_en !== 1'b0 || b_we !== 4'd0 || b_stall !== 1'b0) begin fails++; $display("FAIL mis_strobes got rd=%0h we=%b st=%0h exp=0", b_rd_en, b_we, b_stall); end
    tick();
    tests++; if (b_rv !== 1'b1 || b_rerr !== 1'b1 || b_rwe !== 1'b0) begin fails++; $display("FAIL mis_resp got rv=%0h err=%0h we=%0h exp=1/1/0", b_rv, b_rerr, b_rwe); end
    tests++; if (b_eaddr !== 32'h2002) begin fails++; $display("FAIL mis_addr got=%h exp=00002002", b_eaddr); end
    drive(LH, 32'h2001, 32'd0, 5'd7);
    tick();
    tests++; if (l_rerr !== 1'b1 || l_eaddr !== 32'h2001) begin fails++; $display("FAIL mis_lh got err=%0h ea=%h exp=1/00002001", l_rerr, l_eaddr); end
    req_valid = 1'b0;
  endtask

  task automatic test_enable();
    drive(LW, 32'h0, 32'd0, 5'd3);
    tick();
    en = 1'b0;
    #1;
    tests++; if (b_rd_en !== 1'b0) begin fails++; $display("FAIL en_block got=%0h exp=0", b_rd_en); end
    tick();
    tests++; if (b_rv !== 1'b1 || b_rrd !== 5'd3) begin fails++; $display("FAIL en_hold got rv=%0h rd=%0h exp=1/3", b_rv, b_rrd); end
    en = 1'b1;
    req_valid = 1'b0;
    tick();
    tests++; if (b_rv !== 1'b0) begin fails++; $display("FAIL en_resume got=%0h exp=0", b_rv); end
  endtask

  task automatic test_llsc();
    drive(LL, 32'h40, 32'd0, 5'd1); tick();
    drive(SC, 32'h40, 32'h55, 5'd2);
    tests++; if (b_we !== 4'hF || l_we !== 4'hF) begin fails++; $display("FAIL sc1_we got=%b/%b exp=1111", b_we, l_we); end
    tick();
    tests++; if (b_rdata !== 32'd1 || b_rwe !== 1'b1 || l_rdata !== 32'd1) begin fails++; $display("FAIL sc1_resp got=%h we=%0h exp=1/1", b_rdata, b_rwe); end
    drive(SC, 32'h40, 32'h55, 5'd2);
    tests++; if (b_we !== 4'h0) begin fails++; $display("FAIL sc2_we got=%b exp=0000", b_we); end
    tick();
    tests++; if (b_rdata !== 32'd0 || b_rwe !== 1'b1 || b_rerr !== 1'b0 || b_rv !== 1'b1) begin fails++; $display("FAIL sc2_resp got=%h we=%0h err=%0h exp=0/1/0", b_rdata, b_rwe, b_rerr); end
    drive(LL, 32'h40, 32'd0, 5'd1); tick();
    drive(SW, 32'h44, 32'd9, 5'd0); tick();
    drive(SC, 32'h40, 32'h55, 5'd2);
    tests++; if (b_we !== 4'hF) begin fails++; $display("FAIL sc3_we got=%b exp=1111", b_we); end
    tick();
    tests++; if (b_rdata !== 32'd1) begin fails++; $display("FAIL sc3_resp got=%h exp=1", b_rdata); end
    drive(LL, 32'h40, 32'd0, 5'd1); tick();
    drive(SB, 32'h41, 32'd9, 5'd0); tick();
    drive(SC, 32'h40, 32'h55, 5'd2);
    tests++; if (b_we !== 4'h0) begin fails++; $display("FAIL sc4_we got=%b exp=0000", b_we); end
    tick();
    tests++; if (b_rdata !== 32'd0) begin fails++; $display("FAIL sc4_resp got=%h exp=0", b_rdata); end
    drive(LL, 32'h40, 32'd0, 5'd1);
    llbit_clr = 1'b1;
    tick();
    llbit_clr = 1'b0;
    drive(SC, 32'h40, 32'h55, 5'd2);
    tests++; if (b_we !== 4'h0) begin fails++; $display("FAIL sc_clr_we got=%b exp=0000", b_we); end
    tick();
    tests++; if (b_rdata !== 32'd0) begin fails++; $display("FAIL sc_clr_resp got=%h exp=0", b_rdata); end
    req_valid = 1'b0;
  endtask

  task automatic test_wait();
    tick();
    mem_ready = 1'b0;
    drive(LW, 32'h80, 32'd0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      tests++; if (b_stall !== 1'b1 || l_stall !== 1'b1 || b_rv !== 1'b0) begin fails++; $display("FAIL wait%0d got st=%0h/%0h rv=%0h exp=1/1/0", i, b_stall, l_stall, b_rv); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    tests++; if (b_stall !== 1'b0 || b_rd_en !== 1'b1) begin fails++; $display("FAIL wait_ready got st=%0h rd=%0h exp=0/1", b_stall, b_rd_en); end
    tick();
    tests++; if (b_rv !== 1'b1 || l_rv !== 1'b1 || b_rerr !== 1'b0 || l_rerr !== 1'b0) begin fails++; $display("FAIL wait_resp got rv=%0h/%0h err=%0h/%0h exp=1/1/0/0", b_rv, l_rv, b_rerr, l_rerr); end
    tests++; if (b_rdata !== 32'h8081_7F01) begin fails++; $display("FAIL wait_data got=%h exp=80817f01", b_rdata); end
    req_valid = 1'b0;
  endtask

  task automatic test_timeout();
    tick();
    mem_ready = 1'b0;
    drive(LW, 32'h84, 32'd0, 5'd10);
    for (int i = 0; i < 4; i++) begin
      tests++; if (l_stall !== 1'b1) begin fails++; $display("FAIL to_stall%0d got=%0h exp=1", i, l_stall); end
      tick();
    end
    tests++; if (l_stall !== 1'b0 || b_stall !== 1'b1) begin fails++; $display("FAIL to_hit got le=%0h be=%0h exp=0/1", l_stall, b_stall); end
    tick();
    tests++; if (l_rv !== 1'b1 || l_rerr !== 1'b1 || l_eaddr !== 32'h84) begin fails++; $display("FAIL to_resp got rv=%0h err=%0h ea=%h exp=1/1/84", l_rv, l_rerr, l_eaddr); end
    tests++; if (b_rv !== 1'b0) begin fails++; $display("FAIL to_be_rv got=%0h exp=0", b_rv); end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(LL, 32'h40, 32'd0, 5'd1); tick();
    mem_ready = 1'b0;
    drive(LW, 32'h88, 32'd0, 5'd4);
    tick(); tick();
    tests++; if (b_stall !== 1'b1) begin fails++; $display("FAIL rw_pre got=%0h exp=1", b_stall); end
    #2 rst = 1'b1;
    #1;
    tests++; if (b_stall !== 1'b0 || l_stall !== 1'b0) begin fails++; $display("FAIL rw_stall got=%0h/%0h exp=0/0", b_stall, l_stall); end
    tests++; if (b_rd_en !== 1'b0 || l_rd_en !== 1'b0 || b_rv !== 1'b0) begin fails++; $display("FAIL rw_strobes got rd=%0h/%0h rv=%0h exp=0", b_rd_en, l_rd_en, b_rv); end
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (b_rv !== 1'b0 || l_rv !== 1'b0) begin fails++; $display("FAIL rw_norsp%0d got=%0h/%0h exp=0/0", i, b_rv, l_rv); end
    end
    drive(SC, 32'h40, 32'h55, 5'd2);
    tests++; if (b_we !== 4'h0) begin fails++; $display("FAIL rw_link_we got=%b exp=0000", b_we); end
    tick();
    tests++; if (b_rdata !== 32'd0 || b_rwe !== 1'b1) begin fails++; $display("FAIL rw_link_resp got=%h we=%0h exp=0/1", b_rdata, b_rwe); end
    req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_enable();
    test_llsc();
    test_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
